// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execution-stage ALU with valid/ready handshakes on both sides.
// Supports AND, OR, ADD, SUB (with signed less-than for branches) and SLL.
// Unknown operation codes return result 0 with bad_op set.
// Configuration macro FAST_SHIFT_EN:
//   defined   - SLL uses a one-cycle barrel shifter; no SHIFT state is built.
//   undefined - SLL shifts one bit per cycle, taking shamt cycles in SHIFT.
module alu_exec_unit #(
  parameter int WIDTH   = 64,
  parameter int SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         operation,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               lt,
  output logic               bad_op
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0111;

`ifdef FAST_SHIFT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;
`endif

  state_t               state;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     op_res;
  logic                 op_lt;
  logic                 op_bad;
  logic                 accept;

`ifndef FAST_SHIFT_EN
  logic                 start_shift;
  logic [WIDTH-1:0]     acc;
  logic [SHAMT_W-1:0]   cnt;
  logic [WIDTH-1:0]     acc_next;

  assign acc_next = {acc[WIDTH-2:0], 1'b0};
`endif

  // A new operation can enter when idle, or when the held result retires this edge.
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_ready && in_valid;
  assign shamt    = b[SHAMT_W-1:0];

  // Decode the incoming operation into its single-cycle result and flags.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    op_res = '0;
    op_lt  = 1'b0;
    op_bad = 1'b0;
`ifndef FAST_SHIFT_EN
    start_shift = 1'b0;
`endif
    case (operation)
      OP_AND: op_res = a & b;
      OP_OR:  op_res = a | b;
      OP_ADD: op_res = a + b;
      OP_SUB: begin
        op_res = a - b;
        // Compare the operands directly; the sign of a-b is wrong on overflow.
        op_lt  = $signed(a) < $signed(b);
      end
      OP_SLL: begin
`ifdef FAST_SHIFT_EN
        op_res = a << shamt;
`else
        if (shamt == '0) begin
          op_res = a;
        end else begin
          start_shift = 1'b1;
        end
`endif
      end
      default: op_bad = 1'b1;
    endcase
  end

  // Handshake FSM: capture, optional iterative shift, hold result until retired.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!reset) begin
      // NOTE: acc and cnt are deliberately left out of reset; they are always
      // loaded on entry to SHIFT and never observed outside it.
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      lt        <= 1'b0;
      bad_op    <= 1'b0;
    end else if (accept) begin
`ifndef FAST_SHIFT_EN
      if (start_shift) begin
        state     <= SHIFT;
        out_valid <= 1'b0;
        acc       <= a;
        cnt       <= shamt;
      end else
`endif
      begin
        state     <= DONE;
        out_valid <= 1'b1;
        result    <= op_res;
        zero      <= (op_res == '0);
        lt        <= op_lt;
        bad_op    <= op_bad;
      end
    end else if ((state == DONE) && out_ready) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end
`ifndef FAST_SHIFT_EN
    else if (state == SHIFT) begin
      acc <= acc_next;
      cnt <= cnt - 1'b1;
      if (cnt == SHAMT_W'(1)) begin
        state     <= DONE;
        out_valid <= 1'b1;
        result    <= acc_next;
        zero      <= (acc_next == '0);
        lt        <= 1'b0;
        bad_op    <= 1'b0;
      end
    end
`endif
  end

endmodule
